// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for ID-stage hazard detection, plus post-branch fetch hold and stall counter.
// Outputs are combinational from state and ID inputs; a producer with delay D stalls its dependent exactly D cycles.
module hazard_scoreboard #(
  parameter int NREG       = 32,
  parameter int AW         = $clog2(NREG),
  parameter int FWD_EN     = 1,
  parameter int WB_DEPTH   = 3,
  parameter int LOAD_LAT   = 1,
  parameter int MD_LAT     = 4,
  parameter int BR_PENALTY = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic          id_use_rs1,
  input  logic          id_use_rs2,
  input  logic [AW-1:0] id_rd,
  input  logic          id_reg_write,
  input  logic [1:0]    id_class,
  input  logic          id_branch,
  input  logic          id_jump,
  input  logic          flush,
  output logic          stall,
  output logic          bubble,
  output logic          fetch_hold,
  output logic [31:0]   stall_cycles
);

  localparam int D_ALU = (FWD_EN != 0) ? 0 : WB_DEPTH;
  localparam int D_LD  = (FWD_EN != 0) ? LOAD_LAT : WB_DEPTH;
  localparam int D_MD  = (FWD_EN != 0) ? MD_LAT : ((MD_LAT > WB_DEPTH) ? MD_LAT : WB_DEPTH);
  localparam int MAX_A = (D_ALU > D_LD) ? D_ALU : D_LD;
  localparam int MAXD  = (MAX_A > D_MD) ? MAX_A : D_MD;
  localparam int CW    = (MAXD > 0) ? $clog2(MAXD + 1) : 1;
  localparam int BW    = (BR_PENALTY > 0) ? $clog2(BR_PENALTY + 1) : 1;

  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];
  logic [BW-1:0] ctrl_cnt_q, ctrl_cnt_d;
  logic [31:0]   stall_cycles_q, stall_cycles_d;

  logic          hz_rs1, hz_rs2, stall_raw, issue;
  logic [CW-1:0] d_new, dec;

  always_comb begin
    hz_rs1    = id_use_rs1 && (id_rs1 != '0) && (cnt_q[id_rs1] != '0);
    hz_rs2    = id_use_rs2 && (id_rs2 != '0) && (cnt_q[id_rs2] != '0);
    stall_raw = id_valid && (hz_rs1 || hz_rs2) && !flush;
    issue     = id_valid && !stall_raw && !flush;

    case (id_class)
      2'd1:    d_new = CW'(D_LD);
      2'd2:    d_new = CW'(D_MD);
      default: d_new = CW'(D_ALU);
    endcase

    // Issue loads max(decremented, D) so a short write never shortens a pending long one.
    cnt_d[0] = '0;
    dec      = '0;
    for (int i = 1; i < NREG; i++) begin
      dec      = (cnt_q[i] != '0) ? (cnt_q[i] - 1'b1) : '0;
      cnt_d[i] = dec;
      if (issue && id_reg_write && (id_rd == AW'(i)))
        cnt_d[i] = (dec > d_new) ? dec : d_new;
    end

    ctrl_cnt_d = ctrl_cnt_q;
    if (flush)
      ctrl_cnt_d = '0;
    else if (issue && (id_branch || id_jump))
      ctrl_cnt_d = BW'(BR_PENALTY);
    else if (ctrl_cnt_q != '0)
      ctrl_cnt_d = ctrl_cnt_q - 1'b1;

    stall_cycles_d = stall_cycles_q;
    if (stall_raw && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      ctrl_cnt_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
      ctrl_cnt_q     <= ctrl_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Gated by rst_n so a flush arriving during reset cannot raise bubble.
  assign stall        = rst_n && stall_raw;
  assign bubble       = rst_n && (stall_raw || (flush && id_valid));
  assign fetch_hold   = rst_n && (ctrl_cnt_q != '0);
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Two instances (no forwarding / forwarding) share stimulus; expected stall counts are queued per test.
module tb_hazard_scoreboard;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_branch, id_jump, flush;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic [1:0]    id_class;
  logic          stall0, bubble0, fh0, stall1, bubble1, fh1;
  logic [31:0]   sc0, sc1;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard #(.FWD_EN(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_class(id_class), .id_branch(id_branch), .id_jump(id_jump), .flush(flush),
    .stall(stall0), .bubble(bubble0), .fetch_hold(fh0), .stall_cycles(sc0)
  );

  hazard_scoreboard #(.FWD_EN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_class(id_class), .id_branch(id_branch), .id_jump(id_jump), .flush(flush),
    .stall(stall1), .bubble(bubble1), .fetch_hold(fh1), .stall_cycles(sc1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_reg_write = 0;
    id_branch = 0; id_jump = 0; flush = 0; id_class = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0;
  endtask

  task automatic drain();
    idle();
    repeat (6) tick();
  endtask

  // Hold a reader of rs in ID for 8 cycles and count stall cycles on each instance.
  task automatic count_stalls(input logic [AW-1:0] rs, output int s0, output int s1, output int bad_bubble);
    s0 = 0; s1 = 0; bad_bubble = 0;
    idle();
    id_valid = 1; id_use_rs2 = 1; id_rs2 = rs;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (stall0) s0++;
      if (stall1) s1++;
      if (bubble0 !== stall0 || bubble1 !== stall1) bad_bubble++;
      tick();
    end
    idle();
  endtask

  task automatic dep_test(input string tag, input logic [1:0] cls, input logic [AW-1:0] rd,
                          input int e0, input int e1);
    int s0, s1, bb;
    logic [31:0] b0, b1;
    idle();
    id_valid = 1; id_reg_write = 1; id_rd = rd; id_class = cls;
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    b0 = sc0; b1 = sc1;
    tick();
    count_stalls(rd, s0, s1, bb);
    check_eq({tag, " stalls nofwd"}, s0, exp_q.pop_front());
    check_eq({tag, " stalls fwd"}, s1, exp_q.pop_front());
    check_eq({tag, " stall_cycles nofwd"}, sc0 - b0, e0);
    check_eq({tag, " stall_cycles fwd"}, sc1 - b1, e1);
    check_eq({tag, " bubble==stall"}, bb, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, s1, bb;
    idle();
    #2 rst_n = 0;
    id_valid = 1; id_use_rs1 = 1; id_rs1 = 5; id_rd = 5; id_reg_write = 1; id_class = 2;
    repeat (3) tick();
    @(negedge clk);
    check_eq("reset stall", stall0, 0);
    check_eq("reset fetch_hold", fh0, 0);
    check_eq("reset stall_cycles", sc0, 0);
    flush = 1; id_branch = 1;
    #1;
    check_eq("reset bubble with flush", bubble0, 0);
    check_eq("reset fetch_hold fwd", fh1, 0);
    idle();
    @(negedge clk);
    rst_n = 1;
    tick();
    @(negedge clk);
    check_eq("post-reset stall", stall0, 0);
    tick();

    dep_test("alu", 2'd0, 5'd5, 3, 0);
    dep_test("load", 2'd1, 5'd7, 3, 1);
    dep_test("muldiv", 2'd2, 5'd7, 4, 4);
    dep_test("reserved", 2'd3, 5'd8, 3, 0);

    // Unused source
    idle(); id_valid = 1; id_reg_write = 1; id_rd = 3;
    tick();
    idle(); id_valid = 1; id_rs1 = 3; id_use_rs1 = 0; id_use_rs2 = 1; id_rs2 = 4;
    @(negedge clk);
    check_eq("unused rs1 no stall", stall0, 0);
    id_use_rs1 = 1;
    #1;
    check_eq("used rs1 stalls", stall0, 1);
    id_use_rs1 = 0;
    drain();

    // x0 as destination and source
    idle(); id_valid = 1; id_reg_write = 1; id_rd = 0; id_class = 2;
    tick();
    idle(); id_valid = 1; id_use_rs1 = 1; id_use_rs2 = 1;
    @(negedge clk);
    check_eq("x0 nofwd", stall0, 0);
    check_eq("x0 fwd", stall1, 0);
    drain();

    // WAW: mul then ALU to x9
    idle(); id_valid = 1; id_reg_write = 1; id_rd = 9; id_class = 2;
    exp_q.push_back(3);
    exp_q.push_back(3);
    tick();
    id_class = 0;
    tick();
    count_stalls(5'd9, s0, s1, bb);
    check_eq("waw stalls nofwd", s0, exp_q.pop_front());
    check_eq("waw stalls fwd", s1, exp_q.pop_front());
    drain();

    // Branch fetch hold
    idle(); id_valid = 1; id_branch = 1;
    tick();
    idle();
    @(negedge clk); check_eq("br hold c1", fh0, 1);
    tick();
    @(negedge clk); check_eq("br hold c2", fh1, 1);
    tick();
    @(negedge clk); check_eq("br hold off", fh0, 0);
    drain();

    // Jump, then flush of a hazarding instruction
    idle(); id_valid = 1; id_jump = 1; id_reg_write = 1; id_rd = 11;
    tick();
    idle(); id_valid = 1; flush = 1; id_use_rs1 = 1; id_rs1 = 11;
    id_reg_write = 1; id_rd = 12; id_class = 2; id_branch = 1;
    @(negedge clk);
    check_eq("flush fh before", fh0, 1);
    check_eq("flush stall", stall0, 0);
    check_eq("flush bubble nofwd", bubble0, 1);
    check_eq("flush bubble fwd", bubble1, 1);
    tick();
    idle(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 12;
    @(negedge clk);
    check_eq("flush fh cleared", fh0, 0);
    check_eq("flush no cnt fwd", stall1, 0);
    check_eq("flush no cnt nofwd", stall0, 0);
    drain();

    // Reset mid-countdown
    idle(); id_valid = 1; id_reg_write = 1; id_rd = 13; id_class = 2;
    tick();
    idle(); id_valid = 1; id_use_rs1 = 1; id_rs1 = 13;
    @(negedge clk);
    check_eq("pre-reset stall", stall0, 1);
    rst_n = 0;
    #1;
    check_eq("async reset stall", stall1, 0);
    check_eq("async reset counter", sc0, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    check_eq("release stall", stall0, 0);
    tick();
    @(negedge clk);
    check_eq("release next stall", stall1, 0);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
